freq_divider: RTL and testbench

- Power-of-two clock-frequency divider: produces a 50%-duty output toggling at f_clk / 2^N.
- Fully synchronous; no derived clocks. It is built as an N-bit down-counter clocked by clk, and clkout is the counter MSB.
- Sits in the clocking/utility layer. It is used wherever a slow strobe or a divided reference is needed.
- clkout is a data-domain signal and shall not be used as a clock.

---
 rtl/freq_divider_pkg.sv | 4 +
 rtl/freq_divider_div_stage.sv | 21 ++
 rtl/freq_divider.sv | 37 +++
 tb/tb_freq_divider.sv | 115 +++++++++++
 4 files changed

// File: rtl/freq_divider_pkg.sv
// Shared clocking constants for the divider slice.
package freq_divider_pkg;
  localparam int DEFAULT_DIV_STAGES = 4;
endpackage

// File: rtl/freq_divider_div_stage.sv
// One divider bit: toggle flop that flips when every lower bit is zero (borrow in).
// Latency: q updates on the clk edge; borrow_out is combinational. Backpressure: none.
module div_stage (
  input  logic clk,
  input  logic rst,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (borrow_in) begin
      q <= ~q;
    end
  end

  assign borrow_out = borrow_in & ~q;

endmodule

// File: rtl/freq_divider.sv
// Power-of-two divider: N-bit synchronous down-counter, clkout = count MSB (f_clk / 2^N, 50% duty).
// Latency: clkout is taken straight from the register, no extra stage. Backpressure: none.
module freq_divider
  import freq_divider_pkg::*;
#(
  parameter int N = DEFAULT_DIV_STAGES
) (
  input  logic clk,
  input  logic rst,
  output logic clkout
);

  if (N < 1 || N > 31) begin : g_bad_n
    $error("freq_divider: N=%0d outside legal range 1..31", N);
  end

  logic [N-1:0] count;
  logic [N:0]   borrow;
  logic         unused_borrow;

  assign borrow[0] = 1'b1;

  // Stage k toggles only when stages 0..k-1 are all zero: a synchronous borrow chain.
  for (genvar k = 0; k < N; k++) begin : g_stage
    div_stage u_stage (
      .clk       (clk),
      .rst       (rst),
      .borrow_in (borrow[k]),
      .q         (count[k]),
      .borrow_out(borrow[k+1])
    );
  end

  assign unused_borrow = borrow[N];
  assign clkout        = count[N-1];

endmodule

// File: tb/tb_freq_divider.sv
// Directed bench for freq_divider at N=4 plus N=1,2,5 sweep instances.
module tb_freq_divider;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clkout4, clkout1, clkout2, clkout5;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  freq_divider #(.N(4)) dut4 (.clk(clk), .rst(rst), .clkout(clkout4));
  freq_divider #(.N(1)) dut1 (.clk(clk), .rst(rst), .clkout(clkout1));
  freq_divider #(.N(2)) dut2 (.clk(clk), .rst(rst), .clkout(clkout2));
  freq_divider #(.N(5)) dut5 (.clk(clk), .rst(rst), .clkout(clkout5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // e = edges since release (e >= 1): high for the first half of each 2^n-edge period
  function automatic logic [31:0] exp_clk(input int n, input int e);
    return (((e - 1) % (1 << n)) < (1 << (n - 1))) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n, input int e);
    return 32'(((1 << n) - (e % (1 << n))) % (1 << n));
  endfunction

  initial begin
    int highs;
    int glitches;
    logic a, b;

    // Reset hold
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("reset_clkout4", 32'(clkout4), 32'd0);
      chk("reset_count4", 32'(dut4.count), 32'd0);
    end
    chk("reset_clkout1", 32'(clkout1), 32'd0);
    chk("reset_clkout5", 32'(clkout5), 32'd0);

    // Release and first 17 edges
    rst = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk); #1;
      chk($sformatf("rel_count4_e%0d", e), 32'(dut4.count), exp_cnt(4, e));
      chk($sformatf("rel_clkout4_e%0d", e), 32'(clkout4), exp_clk(4, e));
    end

    // Ten periods: 8 high, 8 low each, output stable between edges
    for (int p = 0; p < 10; p++) begin
      highs    = 0;
      glitches = 0;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        a = clkout4;
        #7;
        b = clkout4;
        if (a) highs++;
        if (a !== b) glitches++;
      end
      chk($sformatf("duty_high_p%0d", p), 32'(highs), 32'd8);
      chk($sformatf("glitch_p%0d", p), 32'(glitches), 32'd0);
    end

    // Count is back at 15; advance to 11 then reset mid-run
    repeat (4) @(posedge clk);
    #1;
    chk("mid_count_before", 32'(dut4.count), 32'd11);
    chk("mid_clkout_before", 32'(clkout4), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_count_reset", 32'(dut4.count), 32'd0);
    chk("mid_clkout_reset", 32'(clkout4), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_count_restart", 32'(dut4.count), 32'd15);
    chk("mid_clkout_restart", 32'(clkout4), 32'd1);

    // Reset pulse that never covers a rising edge must be ignored
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("sync_count", 32'(dut4.count), 32'd14);
    chk("sync_clkout", 32'(clkout4), 32'd1);

    // Parameter sweep from a fresh reset
    rst = 1'b0;
    @(posedge clk); #1;
    chk("sweep_reset_clkout1", 32'(clkout1), 32'd0);
    chk("sweep_reset_clkout2", 32'(clkout2), 32'd0);
    chk("sweep_reset_count5", 32'(dut5.count), 32'd0);
    rst = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      chk($sformatf("n1_clkout_e%0d", e), 32'(clkout1), exp_clk(1, e));
      chk($sformatf("n2_clkout_e%0d", e), 32'(clkout2), exp_clk(2, e));
      chk($sformatf("n5_clkout_e%0d", e), 32'(clkout5), exp_clk(5, e));
      chk($sformatf("n5_count_e%0d", e), 32'(dut5.count), exp_cnt(5, e));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
